alu_ctrl: RTL
=============

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have one clock domain, with an asynchronous, active-low reset.
REQ-002 The block SHALL have no parameters; all widths are fixed: 4-bit data, 3-bit opcode.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command present on cmd_op, cmd_a, cmd_b and cmd_acc.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_op  input  3  ALU select code: 0-3 logic/compare, 4 add, 5 subtract, 6 constant 0000, 7 constant 1111.
REQ-008 cmd_a, cmd_b  input  4 each  operands.
REQ-009 cmd_acc  input  1  when 1, the accumulator replaces cmd_a as operand A.
REQ-010 alu_s  output  3  select code driven to the downstream ALU.
REQ-011 alu_a, alu_b  output  4 each  operands driven to the ALU.
REQ-012 alu_f  input  4  ALU result; combinational from alu_s, alu_a and alu_b.
REQ-013 alu_carry  input  1  ALU carry output.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_f  output  4  captured result.
REQ-017 res_carry  output  1  captured carry.
REQ-018 res_zero  output  1  res_f equals 0000.
REQ-019 op_cnt  output  8  count of completed result handshakes.

Function
REQ-020 The FSM SHALL have three states:
- IDLE: waiting for a command.
- EXEC: ALU settle cycle.
- RESULT: holding a result for the consumer.
REQ-021 cmd_ready SHALL be 1 only in IDLE; it is a registered decode of state.
REQ-022 An accept SHALL occur when cmd_valid and cmd_ready are both 1 at an edge; in cycle T it loads the operand registers and moves the FSM IDLE->EXEC.
- alu_s <= cmd_op
- alu_a <= (cmd_acc ? acc : cmd_a)
- alu_b <= cmd_b
REQ-023 alu_s, alu_a and alu_b SHALL be registered and SHALL change only on an accept; they hold their values in every other state.
REQ-024 In EXEC the block SHALL sample alu_f and alu_carry at the next edge into res_f and res_carry, set res_valid=1, and enter RESULT; the result is visible at T+2.
REQ-025 res_carry SHALL take the value of alu_carry when alu_s is 4 or 5, and SHALL be forced to 0 for all other codes.
REQ-026 res_zero SHALL be a registered flag, captured together with res_f, and SHALL equal (alu_f==4'b0000).
REQ-027 On the same capture edge as res_f, the 4-bit accumulator acc SHALL be loaded with alu_f.
REQ-028 In RESULT, res_f, res_carry, res_zero and res_valid SHALL be held stable while res_ready=0.
REQ-029 In RESULT with res_ready=1 at an edge:
- res_valid -> 0
- op_cnt increments, wrapping 255->0
- FSM moves to IDLE
REQ-030 cmd_valid SHALL be ignored when cmd_ready=0; no command is queued and none is dropped silently once accepted.
REQ-031 The minimum command spacing SHALL be 3 cycles: accept, EXEC, RESULT with res_ready=1.
REQ-032 The block SHALL NOT permit the illegal state encoding; an unused encoding returns to IDLE on the next edge.

Reset
REQ-033 While rst_n=0, regardless of clk, the block SHALL hold the following values:
- state=IDLE
- cmd_ready=1, as a decode of IDLE
- alu_s=0, alu_a=0, alu_b=0
- res_valid=0, res_f=0, res_carry=0, res_zero=0
- acc=0
- op_cnt=0
REQ-034 A reset asserted in EXEC or RESULT SHALL discard the in-flight operation, with no result handshake and no op_cnt increment.
REQ-035 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-036 Add with overflow: accept op=4, a=0111, b=1001, cmd_acc=0 at T -> at T+2 res_valid=1, res_f=0000, res_carry=1, res_zero=1.
REQ-037 Subtract: op=5, a=0011, b=0101 -> res_f=1110, res_carry=0, res_zero=0; op_cnt=1 after a handshake with res_ready=1.
REQ-038 Backpressure: hold res_ready=0 for 5 cycles after res_valid rises -> res_f, res_carry and res_valid are unchanged; cmd_ready=0; a cmd_valid pulse in this window is not accepted.
REQ-039 Accumulator chain: op=4, a=0001, b=0001 gives res_f=0010 -> then op=4, cmd_acc=1, cmd_a=1111, b=0011 -> res_f=0101, res_carry=0.
REQ-040 Carry masking and constant: op=7 -> res_f=1111, res_carry=0 even if alu_carry is forced to 1.
REQ-041 Reset and wrap:
- rst_n low during EXEC -> immediately res_valid=0, cmd_ready=1, acc=0, op_cnt=0.
- 256 completed handshakes -> op_cnt=0.

Source files
------------

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl
//  Purpose  : Sequences one command at a time through an external
//             combinational ALU and holds the captured result for a consumer.
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_acc,
    output logic [2:0] alu_s,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_f,
    input  logic       alu_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_f,
    output logic       res_carry,
    output logic       res_zero,
    output logic [7:0] op_cnt
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_EXEC   = 2'd1;
    localparam logic [1:0] c_RESULT = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'd4;
    localparam logic [2:0] c_OP_SUB = 3'd5;

    logic [1:0] r_state;
    logic       r_cmd_ready;
    logic [2:0] r_alu_s;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [3:0] r_acc;
    logic       r_res_valid;
    logic [3:0] r_res_f;
    logic       r_res_carry;
    logic       r_res_zero;
    logic [7:0] r_op_cnt;

    logic       w_accept;
    logic       w_carry_op;

    assign w_accept   = cmd_valid & r_cmd_ready;
    // Only arithmetic codes produce a meaningful carry from the ALU.
    assign w_carry_op = (r_alu_s == c_OP_ADD) || (r_alu_s == c_OP_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cmd_ready <= 1'b1;
            r_alu_s     <= 3'd0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_acc       <= 4'd0;
            r_res_valid <= 1'b0;
            r_res_f     <= 4'd0;
            r_res_carry <= 1'b0;
            r_res_zero  <= 1'b0;
            r_op_cnt    <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_alu_s     <= cmd_op;
                        r_alu_a     <= cmd_acc ? r_acc : cmd_a;
                        r_alu_b     <= cmd_b;
                        r_state     <= c_EXEC;
                        r_cmd_ready <= 1'b0;
                    end
                end
                c_EXEC: begin
                    r_res_f     <= alu_f;
                    r_res_carry <= w_carry_op ? alu_carry : 1'b0;
                    r_res_zero  <= (alu_f == 4'b0000);
                    r_acc       <= alu_f;
                    r_res_valid <= 1'b1;
                    r_state     <= c_RESULT;
                end
                c_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_op_cnt    <= r_op_cnt + 8'd1;
                        r_state     <= c_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean idle.
                    r_state     <= c_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_s     = r_alu_s;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign res_valid = r_res_valid;
    assign res_f     = r_res_f;
    assign res_carry = r_res_carry;
    assign res_zero  = r_res_zero;
    assign op_cnt    = r_op_cnt;

endmodule
`default_nettype wire
